// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle logical shifter. A request of any shift amount is broken into
// bounded steps of at most STEP_MAX positions per cycle. The operand lives in
// an accumulator that is shifted once per cycle until the requested amount is
// used up, after which the result is published on o_y with a one-cycle
// o_done pulse.
//
// Ports:
//   i_clk    - rising-edge clock
//   i_reset  - asynchronous, active-high reset
//   i_start  - request, sampled only while o_ready is high
//   i_dir    - 0 = logical left, 1 = logical right (sampled with i_start)
//   i_a      - operand, WIDTH bits (sampled with i_start)
//   i_shamt  - total shift amount, SAMT_W bits (sampled with i_start)
//   o_ready  - high while idle and able to accept a request
//   o_busy   - high while shift steps are being applied
//   o_done   - one-cycle pulse when the result is available
//   o_y      - registered result, changes only on entry to DONE
// ---------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH    = 5,
  parameter int SAMT_W   = 3,
  parameter int STEP_MAX = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_dir,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [SAMT_W-1:0] i_shamt,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [WIDTH-1:0]  o_y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SAMT_W-1:0] LP_STEP_MAX = SAMT_W'(STEP_MAX);

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_acc;
  logic [SAMT_W-1:0]  r_rem;
  logic               r_dirQ;
  logic [WIDTH-1:0]   r_y;

  logic [SAMT_W-1:0]  w_step;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_lastStep;

  // Size of the step taken this cycle and the accumulator value it produces.
  // The step is clamped to the remaining amount, so the remainder can never
  // wrap below zero. Amounts at or beyond WIDTH simply drain the accumulator
  // to zero over several steps rather than being special-cased.
  always_comb begin
    w_step     = (r_rem > LP_STEP_MAX) ? LP_STEP_MAX : r_rem;
    w_shifted  = r_dirQ ? (r_acc >> w_step) : (r_acc << w_step);
    w_lastStep = (r_rem <= LP_STEP_MAX);
  end

  // State register. Reset drops any operation in flight straight back to
  // IDLE, so no done pulse can follow a reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode. A zero shift amount goes straight to DONE so that the
  // shifting state is only ever entered with real work to do. DONE always
  // lasts exactly one cycle, which is what makes o_done a single pulse.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = (i_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. The operands are captured only in IDLE, so a start
  // held high while busy or done has no effect on the work in progress. The
  // result register is written only on the transition into DONE and holds its
  // value at every other time.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc  <= '0;
      r_rem  <= '0;
      r_dirQ <= 1'b0;
      r_y    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_acc  <= i_a;
            r_rem  <= i_shamt;
            r_dirQ <= i_dir;
            if (i_shamt == '0) begin
              r_y <= i_a;
            end
          end
        end
        SHIFT: begin
          r_acc <= w_shifted;
          r_rem <= r_rem - w_step;
          if (w_lastStep) begin
            r_y <= w_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs decode directly from the state register.
  assign o_ready = (r_state == IDLE);
  assign o_busy  = (r_state == SHIFT);
  assign o_done  = (r_state == DONE);
  assign o_y     = r_y;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that performs a logical shift of any amount (0..2^SAMT_W-1) using a shift step limited to 0..STEP_MAX positions per cycle.
- Holds the operand in an accumulator and applies one bounded shift per cycle until the requested amount is consumed.
- Presents the result with a done pulse.
- Sits between the ALU control path and the small shift datapath. It sequences large shift amounts that the narrow shifter cannot do in one pass.

Parameters:
- WIDTH, 5, operand/result width in bits.
- SAMT_W, 3, width of the requested shift amount.
- STEP_MAX, 3, maximum positions shifted per cycle; must fit in 2 bits (1..3).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- dir  input  1  0 = logical left, 1 = logical right; sampled with start.
- a  input  WIDTH  operand; sampled with start.
- shamt  input  SAMT_W  total shift amount; sampled with start.
- ready  output  1  high when state is IDLE (combinational from state).
- busy  output  1  high when state is SHIFT.
- done  output  1  one-cycle pulse; high exactly when state is DONE.
- y  output  WIDTH  registered result; updated only on entry to DONE; held otherwise.

Behaviour:
- Internal registers: state (IDLE/SHIFT/DONE), acc[WIDTH], rem[SAMT_W], dir_q.
- Reset (async, immediate, any state):
  - state=IDLE, acc=0, rem=0, dir_q=0, y=0.
  - Resulting outputs: ready=1, busy=0, done=0.
  - Any in-flight operation is discarded; no done pulse follows.
- IDLE:
  - On a clock edge with start=1: acc<=a, rem<=shamt, dir_q<=dir.
  - If shamt==0: next state DONE and y<=a. Otherwise next state SHIFT.
  - With start=0: remain in IDLE.
- SHIFT, each edge:
  - step = min(rem, STEP_MAX).
  - acc <= dir_q ? acc>>step : acc<<step. Logical, zero fill, truncated to WIDTH.
  - rem <= rem-step.
  - If rem<=STEP_MAX: next state DONE and y <= the newly shifted value (the same value written to acc). Otherwise stay in SHIFT.
- DONE: done=1 for one cycle; next state IDLE unconditionally. y holds.
- Latency:
  - SHIFT occupies ceil(shamt/STEP_MAX) cycles.
  - done is high in the cycle following edge number 1+ceil(shamt/STEP_MAX) after the start-sampling edge.
  - Minimum start-to-start period is 2+ceil(shamt/STEP_MAX) cycles.
- start while busy or in DONE is ignored: no queuing, no effect on acc, rem or y. a, shamt and dir may change freely after the sampling edge.
- shamt >= WIDTH yields y=0, computed iteratively with no special-case shortcut.
- rem never underflows, because step <= rem always.
- Exactly one done pulse per accepted start.

Test Plan:
- Reset mid-operation:
  - Stimulus: start with a=11111, dir=0, shamt=7; assert reset during the second SHIFT cycle.
  - Response: immediately ready=1, busy=0, y=00000; no done pulse ever follows.
  - Stimulus: after release, start with a=00011, dir=0, shamt=2.
  - Response: y=01100, done one cycle.
- Basic left shift:
  - Stimulus: after reset, start with a=00011, dir=0, shamt=4.
  - Response: steps 3 then 1; busy high 2 cycles; done high after the 3rd edge; y=10000; ready returns the next cycle.
- Right shift in one step:
  - Stimulus: a=10110, dir=1, shamt=2.
  - Response: one SHIFT cycle; done after the 2nd edge; y=00101.
- Zero shift:
  - Stimulus: a=10101, shamt=0.
  - Response: busy never asserts; done after the 1st edge; y=10101.
- Full-range shift:
  - Stimulus: a=11111, dir=0, shamt=7.
  - Response: steps 3,3,1; busy high 3 cycles; y=00000.
  - Stimulus: same with dir=1.
  - Response: y=00000.
- Ignored start:
  - Stimulus: start a=01000, dir=1, shamt=6; hold start=1 with a=11111, shamt=1 through busy and done.
  - Response: first op completes with y=00000; second op is accepted only at the first edge where ready=1; y=01111 two edges later.
  - Check: exactly one done pulse per accepted op.
